wishbone_line_bridge: RTL
=========================

Name: wishbone_line_bridge

Overview:
- Parametrised, sequential successor to the combinational CPU-word-to-memory-line adapter.
- Accepts one CPU word request at a time and runs it as Wishbone classic line transfers.
- Handles byte-lane steering, masking and read-data extraction.
- Splits any access that crosses a line boundary into two bus transactions.
- Sits between the LC-3b datapath and the line-oriented memory/cache bus.

Parameters:
- ADDR_WIDTH, 16: CPU byte-address width.
- LINE_BYTES, 16: bytes per memory line; power of two, >= WORD_BYTES.
- WORD_BYTES, 2: bytes per CPU word; power of two.
- TIMEOUT_CYCLES, 255: ack wait limit; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_address  in  ADDR_WIDTH  byte address of the word access.
- cpu_read  in  1  read request; held until cpu_resp.
- cpu_write  in  1  write request; held until cpu_resp.
- cpu_byte_enable  in  WORD_BYTES  lane enables; bit i = byte i.
- cpu_wdata  in  8*WORD_BYTES  write data.
- cpu_rdata  out  8*WORD_BYTES  read data; valid while cpu_resp=1.
- cpu_resp  out  1  one-cycle completion pulse.
- cpu_err  out  1  error qualifier with cpu_resp; tied 0 without WB_TIMEOUT_EN.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write enable.
- wb_adr  out  ADDR_WIDTH-log2(LINE_BYTES)  line address.
- wb_sel  out  LINE_BYTES  byte selects.
- wb_dat_w  out  8*LINE_BYTES  write line.
- wb_dat_r  in  8*LINE_BYTES  read line.
- wb_ack  in  1  transfer acknowledge.

Behaviour:
- Reset (synchronous): state IDLE.
  - All outputs 0, including wb_cyc, wb_stb, cpu_resp, cpu_rdata and cpu_err.
  - Latched request cleared. Any ack arriving during the reset cycle is ignored.
- States: IDLE, PHASE0, PHASE1, DONE.
- IDLE:
  - Samples when cpu_read or cpu_write is 1, and latches address, byte_enable, wdata and we.
  - we = cpu_write; write wins if both requests are asserted.
- Lane computation:
  - off = address[log2(LINE_BYTES)-1:0]; line = address >> log2(LINE_BYTES).
  - ext = byte_enable << off, computed (LINE_BYTES+WORD_BYTES) bits wide.
  - sel0 = ext[LINE_BYTES-1:0]; sel1 = ext upper WORD_BYTES bits, zero-extended to LINE_BYTES.
- Transitions:
  - IDLE -> PHASE0 if sel0 != 0.
  - IDLE -> PHASE1 if sel0 == 0 and sel1 != 0.
  - IDLE -> DONE if byte_enable == 0. No bus cycle; cpu_rdata = 0.
- PHASE0:
  - Drives wb_cyc = wb_stb = 1, wb_adr = line, wb_sel = sel0, wb_we = we.
  - wb_dat_w = (wdata AND lane mask) << 8*off, truncated to the line.
  - All bus outputs are held stable until wb_ack.
  - On ack, a read captures the enabled bytes of (wb_dat_r >> 8*off) into the low lanes.
  - Then -> PHASE1 if sel1 != 0, else -> DONE.
- PHASE1:
  - Drives wb_adr = line+1, which wraps modulo 2^(ADDR_WIDTH-log2(LINE_BYTES)).
  - wb_sel = sel1; wb_dat_w carries the upper wdata lanes starting at byte 0.
  - On ack, a read captures wb_dat_r low bytes into the remaining enabled upper lanes. Then -> DONE.
  - wb_cyc stays high from PHASE0 through PHASE1 (block cycle).
  - wb_stb stays high; adr/sel change the cycle after the ack.
- DONE:
  - wb_cyc = wb_stb = 0, cpu_resp = 1 for exactly one cycle, cpu_rdata valid. Then -> IDLE.
  - Disabled lanes read as 0.
- Latency: request sampled in cycle T, PHASE0 in T+1, final ack in cycle A, cpu_resp in A+1.
- wb_ack outside PHASE0/PHASE1 is ignored.
- cpu_rdata holds its value until the next DONE. cpu_resp is never asserted in consecutive cycles.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro defined:
  - Counter clears on entry to each PHASE state and increments every cycle without wb_ack.
  - When it reaches TIMEOUT_CYCLES, the transaction is aborted and the block -> DONE.
  - In DONE after an abort: cpu_err = 1 with cpu_resp, cpu_rdata = 0, and no PHASE1 is attempted.
- Without the macro: no counter is built, the block waits indefinitely, and cpu_err is constant 0.

Test Plan:
- Aligned read at 0x1234, be=11; wb_dat_r byte4=0xAA, byte5=0xBB -> wb_adr=0x123, wb_sel=0x0030, wb_we=0; cpu_rdata=0xBBAA on cycle ack+1.
- Write at 0x00A0, be=01, wdata=0x5678 -> wb_adr=0x00A, wb_sel=0x0001, wb_we=1, wb_dat_w byte0=0x78, all other bytes 0; one resp pulse.
- Line-crossing read at 0x002F, be=11 -> PHASE0 adr=0x002 sel=0x8000, then PHASE1 adr=0x003 sel=0x0001, wb_cyc continuous; cpu_rdata={line3 byte0, line2 byte15}.
- Wrap write at 0xFFFF, be=11, wdata=0x1234 -> phase0 adr=0xFFF sel=0x8000 byte15=0x34; phase1 adr=0x000 sel=0x0001 byte0=0x12.
- rst=1 during PHASE0, with wb_ack=1 in the same cycle -> next cycle wb_cyc=wb_stb=0, state IDLE, cpu_resp stays 0.
- WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, wb_ack held 0 -> cpu_resp=cpu_err=1 eight cycles after PHASE0 entry plus one; bus released.

Source files
------------

// File: rtl/wishbone_line_bridge.sv
// ---------------------------------------------------------------------------
// wishbone_line_bridge
//
// Purpose:
//   Sequential bridge between a CPU word port (LC-3b datapath side) and a
//   line-oriented Wishbone classic bus. It accepts one word request at a time,
//   steers the word's byte lanes into the correct position inside a memory
//   line, and extracts read data back into the low lanes. An access that
//   straddles a line boundary is issued as two consecutive transfers inside a
//   single bus cycle (wb_cyc held high across both).
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   cpu_address      byte address of the word access
//   cpu_read/write   request strobes, held until cpu_resp (write wins)
//   cpu_byte_enable  lane enables, bit i = byte i of the word
//   cpu_wdata        write data
//   cpu_rdata        read data, valid with cpu_resp, held until next completion
//   cpu_resp         one-cycle completion pulse
//   cpu_err          error qualifier for cpu_resp (timeout abort)
//   wb_*             Wishbone classic master: cyc, stb, we, line address,
//                    byte selects, write line, read line, ack
//
// Configuration:
//   WB_TIMEOUT_EN    when defined, an ack wait longer than TIMEOUT_CYCLES
//                    aborts the transfer and completes with cpu_err = 1.
//                    When undefined the bridge waits indefinitely.
// ---------------------------------------------------------------------------
module wishbone_line_bridge #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned LINE_BYTES     = 16,
    parameter int unsigned WORD_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ADDR_WIDTH-1:0]                      cpu_address,
    input  logic                                       cpu_read,
    input  logic                                       cpu_write,
    input  logic [WORD_BYTES-1:0]                      cpu_byte_enable,
    input  logic [8*WORD_BYTES-1:0]                    cpu_wdata,
    output logic [8*WORD_BYTES-1:0]                    cpu_rdata,
    output logic                                       cpu_resp,
    output logic                                       cpu_err,
    output logic                                       wb_cyc,
    output logic                                       wb_stb,
    output logic                                       wb_we,
    output logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0]   wb_adr,
    output logic [LINE_BYTES-1:0]                      wb_sel,
    output logic [8*LINE_BYTES-1:0]                    wb_dat_w,
    input  logic [8*LINE_BYTES-1:0]                    wb_dat_r,
    input  logic                                       wb_ack
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned LADR_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned EXT_W  = LINE_BYTES + WORD_BYTES;
    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned LINE_W = 8 * LINE_BYTES;
    localparam int unsigned DEXT_W = 8 * EXT_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PHASE0 = 2'd1;
    localparam logic [1:0] PHASE1 = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_BYTES-1:0] be_q, be_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [WORD_W-1:0]     rbuf_q, rbuf_d;   // lanes captured in PHASE0
    logic [WORD_W-1:0]     rdata_q, rdata_d;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timed_out;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

    // Lane computation. In IDLE the live inputs decide the first state;
    // afterwards everything is derived from the latched request.
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WORD_BYTES-1:0] cur_be;
    logic [OFF_W-1:0]      off;
    logic [LADR_W-1:0]     line_adr;
    logic [OFF_W+2:0]      byte_shift;
    logic [EXT_W-1:0]      ext;
    logic [LINE_BYTES-1:0] sel0, sel1;
    logic [WORD_W-1:0]     lane_mask;
    logic [DEXT_W-1:0]     wext;
    logic [LINE_W-1:0]     wr_lo, wr_hi;
    logic [2*LINE_W-1:0]   rd_src;
    logic [WORD_W-1:0]     rd_lanes;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_addr   = (state_q == IDLE) ? cpu_address     : addr_q;
        cur_be     = (state_q == IDLE) ? cpu_byte_enable : be_q;
        off        = cur_addr[OFF_W-1:0];
        line_adr   = cur_addr[ADDR_WIDTH-1:OFF_W];
        byte_shift = {off, 3'b000};

        ext  = EXT_W'(cur_be) << off;
        sel0 = ext[LINE_BYTES-1:0];
        sel1 = '0;
        sel1[WORD_BYTES-1:0] = ext[EXT_W-1:LINE_BYTES];

        lane_mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            lane_mask[8*i +: 8] = {8{cur_be[i]}};
        end

        // Write data shifted into a line-plus-word window: the low line goes
        // out in PHASE0, the spill-over lanes start at byte 0 in PHASE1.
        wext  = DEXT_W'(wdata_q & lane_mask) << byte_shift;
        wr_lo = wext[LINE_W-1:0];
        wr_hi = '0;
        wr_hi[WORD_W-1:0] = wext[DEXT_W-1:LINE_W];

        // Placing the PHASE1 line above a zero line lets one shifter serve
        // both phases: in PHASE1 only the lanes past the boundary are nonzero,
        // so they can simply be OR-ed onto the PHASE0 capture.
        rd_src   = (state_q == PHASE1) ? {wb_dat_r, {LINE_W{1'b0}}}
                                       : {{LINE_W{1'b0}}, wb_dat_r};
        rd_lanes = WORD_W'(rd_src >> byte_shift) & lane_mask;
    end

    // Next-state and request latching.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    addr_d  = cpu_address;
                    be_d    = cpu_byte_enable;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_write;
                    rbuf_d  = '0;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                    if (sel0 != '0) begin
                        state_d = PHASE0;
                    end else if (sel1 != '0) begin
                        state_d = PHASE1;
                    end else begin
                        state_d = DONE;
                        rdata_d = '0;
                    end
                end
            end
            PHASE0: begin
                if (wb_ack) begin
                    rbuf_d = we_q ? '0 : rd_lanes;
                    if (sel1 != '0) begin
                        state_d = PHASE1;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = DONE;
                        rdata_d = we_q ? '0 : rd_lanes;
                    end
                end
`ifdef WB_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            PHASE1: begin
                if (wb_ack) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : (rbuf_q | rd_lanes);
                end
`ifdef WB_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;  // DONE lasts exactly one cycle
        endcase
    end

    // Bus and CPU outputs decode from the state; idle/done drive all zeros.
    always_comb begin
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_adr   = '0;
        wb_sel   = '0;
        wb_dat_w = '0;
        case (state_q)
            PHASE0: begin
                wb_cyc   = 1'b1;
                wb_stb   = 1'b1;
                wb_we    = we_q;
                wb_adr   = line_adr;
                wb_sel   = sel0;
                wb_dat_w = wr_lo;
            end
            PHASE1: begin
                wb_cyc   = 1'b1;
                wb_stb   = 1'b1;
                wb_we    = we_q;
                wb_adr   = line_adr + LADR_W'(1);  // wraps at the top line
                wb_sel   = sel1;
                wb_dat_w = wr_hi;
            end
            default: ;
        endcase
        cpu_resp  = (state_q == DONE);
        cpu_rdata = rdata_q;
`ifdef WB_TIMEOUT_EN
        cpu_err   = (state_q == DONE) && err_q;
`else
        cpu_err   = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole request/data set is reset, not just the state:
            // it is a handful of flops and cpu_rdata must read 0 after reset.
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule
